// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/ready bus between the fetch
//                stage (master) and instruction memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage with IF/ID pipeline register. Owns
//                the PC, issues req/ready fetches, buffers a fetch that
//                completes under stall, and drains an outstanding request
//                after a redirect before restarting at the new target.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire              clk,
    input  wire              rst,
    fetch_unit_if.master     imem,
    input  wire              stall,
    input  wire              redirect,
    input  wire  [XLEN-1:0]  redirect_pc,
    output logic             if_id_valid,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_pc4,
    output logic [XLEN-1:0]  if_id_instr,
    output logic [6:0]       if_id_opcode
);

    // addi x0,x0,0 -- decode-safe filler for every empty IF/ID slot
    localparam logic [XLEN-1:0] c_NOP        = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] c_FOUR       = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // FETCH : request at pc
    // BUFFER: fetched word parked while decode is stalled, no request
    // DRAIN : old request still in flight after a redirect; its data is dropped
    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_BUFFER = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] r_buf_pc;
    logic [XLEN-1:0] r_buf_instr;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;

    logic            w_req;
    logic            w_xfer;
    logic [XLEN-1:0] w_rpc;
    logic [XLEN-1:0] w_pc_inc;

    // Request/handshake decode; the address is only ever r_pc, which does not
    // move while a request is outstanding, so it is stable until ready.
    always_comb begin
        w_req    = !rst && (r_state != S_BUFFER);
        w_xfer   = w_req && imem.imem_ready;
        w_rpc    = redirect_pc & c_ALIGN_MASK;
        w_pc_inc = r_pc + c_FOUR;
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    // PC, fetch state machine, skid buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_pend_pc   <= RESET_PC;
            r_buf_pc    <= '0;
            r_buf_instr <= c_NOP;
            r_if_valid  <= 1'b0;
            r_if_pc     <= '0;
            r_if_instr  <= c_NOP;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (redirect) begin
                        // Flush wins over stall: the wrong-path slot must go.
                        r_if_valid <= 1'b0;
                        r_if_instr <= c_NOP;
                        if (w_xfer) begin
                            r_pc <= w_rpc;
                        end else begin
                            r_pend_pc <= w_rpc;
                            r_state   <= S_DRAIN;
                        end
                    end else if (w_xfer) begin
                        r_pc <= w_pc_inc;
                        if (stall) begin
                            r_buf_pc    <= r_pc;
                            r_buf_instr <= imem.imem_rdata;
                            r_state     <= S_BUFFER;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_instr <= imem.imem_rdata;
                        end
                    end else if (!stall) begin
                        // Memory wait with decode free: insert a bubble.
                        r_if_valid <= 1'b0;
                        r_if_instr <= c_NOP;
                    end
                end

                S_BUFFER: begin
                    if (redirect) begin
                        r_if_valid <= 1'b0;
                        r_if_instr <= c_NOP;
                        r_pc       <= w_rpc;
                        r_state    <= S_FETCH;
                    end else if (!stall) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_buf_pc;
                        r_if_instr <= r_buf_instr;
                        r_state    <= S_FETCH;
                    end
                end

                S_DRAIN: begin
                    r_if_valid <= 1'b0;
                    r_if_instr <= c_NOP;
                    if (redirect) begin
                        r_pend_pc <= w_rpc;
                    end
                    if (w_xfer) begin
                        // The in-flight word belongs to the old path: drop it.
                        r_pc    <= redirect ? w_rpc : r_pend_pc;
                        r_state <= S_FETCH;
                    end
                end

                default: begin
                    r_state    <= S_FETCH;
                    r_if_valid <= 1'b0;
                    r_if_instr <= c_NOP;
                end
            endcase
        end
    end

    // IF/ID outputs; the link value is derived so it can never disagree
    always_comb begin
        if_id_valid  = r_if_valid;
        if_id_pc     = r_if_pc;
        if_id_pc4    = r_if_pc + c_FOUR;
        if_id_instr  = r_if_instr;
        if_id_opcode = r_if_instr[6:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed vector table,
//                randomized traffic against a behavioural model, and a
//                RESET_PC wrap-around sequence on a second instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_K   = 32'hA5A5_0000;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
    logic [6:0]  if_id_opcode;

    logic        rst_w;
    logic        if_id_valid_w;
    logic [31:0] if_id_pc_w, if_id_pc4_w, if_id_instr_w;
    logic [6:0]  if_id_opcode_w;

    int n_vec;
    int n_err;

    fetch_unit_if #(.XLEN(32)) bus  ();
    fetch_unit_if #(.XLEN(32)) busw ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .imem(bus.master),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
        .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst_w), .imem(busw.master),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .if_id_valid(if_id_valid_w), .if_id_pc(if_id_pc_w), .if_id_pc4(if_id_pc4_w),
        .if_id_instr(if_id_instr_w), .if_id_opcode(if_id_opcode_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Fetch viewed as: a PC, an optional parked word, and an optional
    // "discard the word in flight, then jump to target" obligation.
    logic [31:0] m_pc;
    bit          m_have_buf;
    logic [31:0] m_buf_pc, m_buf_instr;
    bit          m_dropping;
    logic [31:0] m_target;
    bit          m_valid;
    logic [31:0] m_ifpc, m_ifinstr;
    bit          m_after_reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rdy, input bit st, input bit rd,
                              input logic [31:0] rpc_raw);
        logic [31:0] rpc;
        logic [31:0] data;
        bit          xfer;
        rpc  = rpc_raw & 32'hFFFF_FFFC;
        data = m_pc ^ c_K;
        xfer = !m_have_buf && rdy;
        m_after_reset = r;
        if (r) begin
            m_pc = 32'h0; m_have_buf = 0; m_dropping = 0;
            m_valid = 0; m_ifpc = 32'h0; m_ifinstr = c_NOP;
        end else if (m_dropping) begin
            if (rd) m_target = rpc;
            if (xfer) begin
                m_pc = m_target;
                m_dropping = 0;
            end
            m_valid = 0; m_ifinstr = c_NOP;
        end else if (m_have_buf) begin
            if (rd) begin
                m_have_buf = 0; m_pc = rpc; m_valid = 0; m_ifinstr = c_NOP;
            end else if (!st) begin
                m_have_buf = 0; m_valid = 1; m_ifpc = m_buf_pc; m_ifinstr = m_buf_instr;
            end
        end else if (rd) begin
            m_valid = 0; m_ifinstr = c_NOP;
            if (xfer) m_pc = rpc;
            else begin
                m_dropping = 1; m_target = rpc;
            end
        end else if (xfer) begin
            if (st) begin
                m_have_buf = 1; m_buf_pc = m_pc; m_buf_instr = data;
            end else begin
                m_valid = 1; m_ifpc = m_pc; m_ifinstr = data;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_valid = 0; m_ifinstr = c_NOP;
        end
    endtask

    // Inputs change at the falling edge; combinational outputs sampled 1ns later
    task automatic drive(input bit r, input bit rdy, input bit st, input bit rd,
                         input logic [31:0] rpc);
        @(negedge clk);
        rst = r; bus.imem_ready = rdy; bus.imem_rdata = m_pc ^ c_K;
        stall = st; redirect = rd; redirect_pc = rpc;
        #1;
    endtask

    task automatic check_comb_model(input bit r);
        chk("req", {31'b0, bus.imem_req}, {31'b0, (!r && !m_have_buf)});
        chk("addr", bus.imem_addr, m_pc);
    endtask

    task automatic check_regs_model();
        chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("instr", if_id_instr, m_ifinstr);
        chk("opcode", {25'b0, if_id_opcode}, {25'b0, m_ifinstr[6:0]});
        if (m_valid || m_after_reset) begin
            chk("if_pc", if_id_pc, m_ifpc);
            chk("if_pc4", if_id_pc4, m_ifpc + 32'd4);
        end
    endtask

    task automatic tick(input bit r, input bit rdy, input bit st, input bit rd,
                        input logic [31:0] rpc);
        model_step(r, rdy, st, rd, rpc);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst, rdy, stl, rdr;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[23];

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
        bus.imem_ready = 0; bus.imem_rdata = 0;
        rst_w = 1; busw.imem_ready = 0; busw.imem_rdata = 0;
        m_pc = 0; m_have_buf = 0; m_dropping = 0; m_target = 0;
        m_buf_pc = 0; m_buf_instr = c_NOP;
        m_valid = 0; m_ifpc = 0; m_ifinstr = c_NOP; m_after_reset = 1;

        //          rst rdy stl rdr rpc           req addr          valid pc
        tbl[0]  = '{1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[1]  = '{0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0};
        tbl[2]  = '{0, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h4};
        tbl[3]  = '{0, 0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h0};
        tbl[4]  = '{0, 0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h0};
        tbl[5]  = '{0, 0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h0};
        tbl[6]  = '{0, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h8};
        tbl[7]  = '{0, 1, 1, 0, 32'h0,        1, 32'hC,        1, 32'h8};
        tbl[8]  = '{0, 0, 1, 0, 32'h0,        0, 32'h10,       1, 32'h8};
        tbl[9]  = '{0, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'hC};
        tbl[10] = '{0, 1, 0, 0, 32'h0,        1, 32'h10,       1, 32'h10};
        tbl[11] = '{0, 0, 0, 1, 32'h100,      1, 32'h14,       0, 32'h0};
        tbl[12] = '{0, 0, 0, 0, 32'h0,        1, 32'h14,       0, 32'h0};
        tbl[13] = '{0, 1, 0, 0, 32'h0,        1, 32'h14,       0, 32'h0};
        tbl[14] = '{0, 1, 0, 0, 32'h0,        1, 32'h100,      1, 32'h100};
        tbl[15] = '{0, 1, 0, 0, 32'h0,        1, 32'h104,      1, 32'h104};
        tbl[16] = '{0, 1, 1, 0, 32'h0,        1, 32'h108,      1, 32'h104};
        tbl[17] = '{0, 0, 1, 1, 32'h203,      0, 32'h10C,      0, 32'h0};
        tbl[18] = '{0, 1, 0, 0, 32'h0,        1, 32'h200,      1, 32'h200};
        tbl[19] = '{0, 0, 0, 1, 32'h300,      1, 32'h204,      0, 32'h0};
        tbl[20] = '{0, 0, 0, 1, 32'h400,      1, 32'h204,      0, 32'h0};
        tbl[21] = '{1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[22] = '{0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0};

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].stl, tbl[i].rdr, tbl[i].rpc);
            chk($sformatf("tbl%0d_req", i), {31'b0, bus.imem_req}, {31'b0, tbl[i].e_req});
            if (!tbl[i].rst)
                chk($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
            check_comb_model(tbl[i].rst);
            tick(tbl[i].rst, tbl[i].rdy, tbl[i].stl, tbl[i].rdr, tbl[i].rpc);
            chk($sformatf("tbl%0d_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_instr", i), if_id_instr,
                tbl[i].e_valid ? (tbl[i].e_pc ^ c_K) : c_NOP);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), if_id_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_pc4", i), if_id_pc4, tbl[i].e_pc + 32'd4);
            end
            if (tbl[i].rst) begin
                chk($sformatf("tbl%0d_rst_pc", i), if_id_pc, 32'h0);
                chk($sformatf("tbl%0d_rst_pc4", i), if_id_pc4, 32'h4);
            end
            check_regs_model();
        end

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 400; i++) begin
            bit r, rdy, st, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) < 1);
            rdy = ($urandom_range(0, 99) < 70);
            st  = ($urandom_range(0, 99) < 25);
            rd  = ($urandom_range(0, 99) < 8);
            rpc = $urandom;
            drive(r, rdy, st, rd, rpc);
            check_comb_model(r);
            tick(r, rdy, st, rd, rpc);
            check_regs_model();
        end

        // ---------------- RESET_PC wrap-around on second instance ----------------
        @(negedge clk);
        rst_w = 1; busw.imem_ready = 1; busw.imem_rdata = 32'hFFFF_FFFC ^ c_K;
        #1;
        chk("wrap_req_in_rst", {31'b0, busw.imem_req}, 32'h0);
        @(negedge clk);
        rst_w = 0;
        #1;
        chk("wrap_addr0", busw.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req", {31'b0, busw.imem_req}, 32'h1);
        @(negedge clk);
        busw.imem_rdata = 32'h0 ^ c_K;
        #1;
        chk("wrap_addr1", busw.imem_addr, 32'h0);
        chk("wrap_if_pc", if_id_pc_w, 32'hFFFF_FFFC);
        chk("wrap_if_pc4", if_id_pc4_w, 32'h0);
        chk("wrap_if_instr", if_id_instr_w, 32'hFFFF_FFFC ^ c_K);
        @(negedge clk);
        busw.imem_ready = 0;
        #1;
        chk("wrap_if_pc_next", if_id_pc_w, 32'h0);
        chk("wrap_addr2", busw.imem_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
